vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl
Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync-pulse pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync-pulse lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back-porch lines.
REQ-009 SHALL have port iVGA_CLK  input  1  pixel clock, 25 MHz nominal, rising edge.
REQ-010 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-011 SHALL have port iRed / iGreen / iBlue  input  1 each  pixel colour from pattern stage, registered there one cycle after X/Y.
REQ-012 SHALL have port oVGA_X  output  10  current pixel column, 0 when outside visible columns.
REQ-013 SHALL have port oVGA_Y  output  10  current line, 0 when outside visible lines.
REQ-014 SHALL have port oVGA_HS  output  1  horizontal sync, active-low.
REQ-015 SHALL have port oVGA_VS  output  1  vertical sync, active-low.
REQ-016 SHALL have port oVGA_BLANK_N  output  1  high only during visible region.
REQ-017 SHALL have port oVGA_R / oVGA_G / oVGA_B  output  1 each  colour to DAC pins.
REQ-018 SHALL have port oFrame_start  output  1  one-cycle pulse at first pixel of each frame.
Function
REQ-019 SHALL keep registered h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800 default), incrementing every cycle, wrapping to 0.
REQ-020 SHALL keep registered v_cnt 0..V_TOTAL-1 (525 default), incrementing only on the cycle h_cnt wraps; v_cnt wraps to 0 when h_cnt and v_cnt wrap together.
REQ-021 SHALL drive oVGA_X = h_cnt when h_cnt < H_VISIBLE else 0, and oVGA_Y = v_cnt when v_cnt < V_VISIBLE else 0, combinationally from counters (stage 0).
REQ-022 SHALL derive stage-0 hs low for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 default).
REQ-023 SHALL derive stage-0 vs low for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 default), for every pixel of those lines.
REQ-024 SHALL derive stage-0 blank_n = (h_cnt < H_VISIBLE) AND (v_cnt < V_VISIBLE).
REQ-025 SHALL delay hs/vs/blank_n one cycle (stage 1) so they align with iRed/iGreen/iBlue.
REQ-026 SHALL register oVGA_HS/VS/BLANK_N from stage 1 and oVGA_R/G/B = iColour AND stage-1 blank_n (stage 2); total latency counters-to-pins = 2 cycles.
REQ-027 SHALL force oVGA_R/G/B to 0 whenever stage-1 blank_n is 0, regardless of iRed/iGreen/iBlue.
REQ-028 SHALL assert oFrame_start (registered) for exactly one cycle, the cycle after h_cnt = 0 and v_cnt = 0.
REQ-029 SHALL use only counter comparisons; no division or modulo in timing logic.
Reset
REQ-030 SHALL on reset asynchronously set h_cnt = v_cnt = 0, oVGA_HS = oVGA_VS = 1, oVGA_BLANK_N = 0, oVGA_R/G/B = 0, oFrame_start = 0, stage-1 registers to inactive (hs=vs=1, blank_n=0); oVGA_X = oVGA_Y = 0 follows.
REQ-031 SHALL on reset asserted mid-frame abort the frame and, after release, restart at h_cnt = 0, v_cnt = 0 on the first clock edge, with oFrame_start pulsing on the following edge.
Configuration
REQ-032 SHALL, when macro VGA_BORDER_EN is defined, force stage-2 oVGA_R/G/B = 1,1,1 for visible pixels with column 0, column H_VISIBLE-1, line 0 or line V_VISIBLE-1; when undefined, colours pass per REQ-026 with no border logic synthesised.
Verification
REQ-033 SHALL verify: release reset, hold iRed=1 -> first oVGA_HS falling edge 658 cycles after release, low for exactly 96 cycles, period 800 cycles.
REQ-034 SHALL verify: free-run -> oVGA_VS low for exactly 1600 cycles starting at line 490 (+2 cycles latency), frame period 420000 cycles, oFrame_start spaced 420000 cycles.
REQ-035 SHALL verify: iRed=iGreen=iBlue=1 constant -> oVGA_R/G/B = 1 for exactly 640x480 = 307200 cycles per frame, 0 whenever oVGA_BLANK_N = 0.
REQ-036 SHALL verify: reset pulsed at h_cnt=300, v_cnt=200 -> outputs at reset values immediately, oVGA_X = 0, then counting resumes from 0,0.
REQ-037 SHALL verify: with VGA_BORDER_EN, iRed=iGreen=iBlue=0 -> white only at X=0, X=639, Y=0, Y=479; without it, all-zero colour output.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing generator. Free-running h/v counters
//               produce X/Y coordinates (stage 0). Sync and blanking are
//               delayed one cycle (stage 1) to line up with the pattern
//               stage's registered colour, then registered to the pins
//               (stage 2). Counter-to-pin latency is 2 cycles.
//               Optional: define VGA_BORDER_EN to force a white one-pixel
//               frame around the visible area.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic       iRed,
    input  logic       iGreen,
    input  logic       iBlue,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N,
    output logic       oVGA_R,
    output logic       oVGA_G,
    output logic       oVGA_B,
    output logic       oFrame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] c_h_last     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] c_v_last     = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] c_h_vis      = H_W'(H_VISIBLE);
    localparam logic [V_W-1:0] c_v_vis      = V_W'(V_VISIBLE);
    localparam logic [H_W-1:0] c_h_vis_last = H_W'(H_VISIBLE - 1);
    localparam logic [V_W-1:0] c_v_vis_last = V_W'(V_VISIBLE - 1);
    localparam logic [H_W-1:0] c_hs_start   = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] c_hs_end     = H_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [V_W-1:0] c_vs_start   = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] c_vs_end     = V_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           frame_start_q, frame_start_d;
    logic           hs_s1_q, hs_s1_d;
    logic           vs_s1_q, vs_s1_d;
    logic           blank_s1_q, blank_s1_d;
    logic           hs_out_q, hs_out_d;
    logic           vs_out_q, vs_out_d;
    logic           blank_out_q, blank_out_d;
    logic           r_out_q, r_out_d;
    logic           g_out_q, g_out_d;
    logic           b_out_q, b_out_d;
    logic           h_vis, v_vis;
`ifdef VGA_BORDER_EN
    logic           border_s1_q, border_s1_d;
`endif

    // Next-state counters, stage-0 decode and stage-2 colour gating
    always_comb begin
        h_vis       = (h_cnt_q < c_h_vis);
        v_vis       = (v_cnt_q < c_v_vis);
        h_cnt_d     = h_cnt_q + 1'b1;
        v_cnt_d     = v_cnt_q;
        if (h_cnt_q == c_h_last) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
        end
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

        hs_s1_d    = !((h_cnt_q >= c_hs_start) && (h_cnt_q <= c_hs_end));
        vs_s1_d    = !((v_cnt_q >= c_vs_start) && (v_cnt_q <= c_vs_end));
        blank_s1_d = h_vis && v_vis;

        hs_out_d    = hs_s1_q;
        vs_out_d    = vs_s1_q;
        blank_out_d = blank_s1_q;
`ifdef VGA_BORDER_EN
        border_s1_d = h_vis && v_vis &&
                      ((h_cnt_q == '0) || (h_cnt_q == c_h_vis_last) ||
                       (v_cnt_q == '0) || (v_cnt_q == c_v_vis_last));
        r_out_d = blank_s1_q && (iRed   || border_s1_q);
        g_out_d = blank_s1_q && (iGreen || border_s1_q);
        b_out_d = blank_s1_q && (iBlue  || border_s1_q);
`else
        r_out_d = blank_s1_q && iRed;
        g_out_d = blank_s1_q && iGreen;
        b_out_d = blank_s1_q && iBlue;
`endif
    end

    // Raster counters and frame-start pulse
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Stage-1 alignment registers and stage-2 pin registers
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            blank_s1_q  <= 1'b0;
            hs_out_q    <= 1'b1;
            vs_out_q    <= 1'b1;
            blank_out_q <= 1'b0;
            r_out_q     <= 1'b0;
            g_out_q     <= 1'b0;
            b_out_q     <= 1'b0;
`ifdef VGA_BORDER_EN
            border_s1_q <= 1'b0;
`endif
        end else begin
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            blank_s1_q  <= blank_s1_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
            blank_out_q <= blank_out_d;
            r_out_q     <= r_out_d;
            g_out_q     <= g_out_d;
            b_out_q     <= b_out_d;
`ifdef VGA_BORDER_EN
            border_s1_q <= border_s1_d;
`endif
        end
    end

    assign oVGA_X       = h_vis ? 10'(h_cnt_q) : 10'd0;
    assign oVGA_Y       = v_vis ? 10'(v_cnt_q) : 10'd0;
    assign oVGA_HS      = hs_out_q;
    assign oVGA_VS      = vs_out_q;
    assign oVGA_BLANK_N = blank_out_q;
    assign oVGA_R       = r_out_q;
    assign oVGA_G       = g_out_q;
    assign oVGA_B       = b_out_q;
    assign oFrame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Self-checking bench for vga_timing_ctrl using a reduced
//               raster (32x19) so that several frames run quickly. A raster
//               model pushes expected pin values into a scoreboard queue as
//               colour stimulus is driven; they are popped one cycle later
//               when the registered pins carry them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    localparam int HV = 16, HF = 4, HSY = 8, HB = 4;
    localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       i_red = 1'b0, i_green = 1'b0, i_blue = 1'b0;
    logic [9:0] x, y;
    logic       hs, vs, blank_n, r, g, b, fs;

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .iVGA_CLK    (clk),
        .reset       (reset),
        .iRed        (i_red),
        .iGreen      (i_green),
        .iBlue       (i_blue),
        .oVGA_X      (x),
        .oVGA_Y      (y),
        .oVGA_HS     (hs),
        .oVGA_VS     (vs),
        .oVGA_BLANK_N(blank_n),
        .oVGA_R      (r),
        .oVGA_G      (g),
        .oVGA_B      (b),
        .oFrame_start(fs)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic hs; logic vs; logic blank; logic border;} st0_t;
    typedef struct packed {logic hs; logic vs; logic blank; logic r; logic g; logic b;} pins_t;

    pins_t sb[$];
    int    checks = 0;
    int    failures = 0;

    int    mh, mv;
    st0_t  prev;
    logic  prev_origin;
    int    blank_cnt, hs_low_cnt, vs_low_cnt, fs_cnt, first_hs_fall;
    logic  last_hs;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic st0_t stage0(input int h, input int v);
        st0_t s;
        s.hs     = (h >= HV + HF && h < HV + HF + HSY) ? 1'b0 : 1'b1;
        s.vs     = (v >= VV + VF && v < VV + VF + VSY) ? 1'b0 : 1'b1;
        s.blank  = (h < HV && v < VV) ? 1'b1 : 1'b0;
        s.border = (s.blank && (h == 0 || h == HV - 1 || v == 0 || v == VV - 1)) ? 1'b1 : 1'b0;
        return s;
    endfunction

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_x"},  32'(x), 0);
        check_eq({pfx, "_y"},  32'(y), 0);
        check_eq({pfx, "_hs"}, 32'(hs), 1);
        check_eq({pfx, "_vs"}, 32'(vs), 1);
        check_eq({pfx, "_blank"}, 32'(blank_n), 0);
        check_eq({pfx, "_rgb"}, 32'({r, g, b}), 0);
        check_eq({pfx, "_fs"}, 32'(fs), 0);
    endtask

    // Release reset at a falling edge and run n cycles against the model.
    task automatic run_cycles(input int n);
        pins_t      e;
        pins_t      got;
        st0_t       cur;
        logic [2:0] col;
        logic       bd;
        mh = 0; mv = 0;
        prev = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, border: 1'b0};
        prev_origin = 1'b0;
        sb.delete();
        sb.push_back(pins_t'(6'b110000));
        blank_cnt = 0; hs_low_cnt = 0; vs_low_cnt = 0; fs_cnt = 0;
        first_hs_fall = -1; last_hs = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_eq("x", 32'(x), (mh < HV) ? 32'(mh) : 32'd0);
            check_eq("y", 32'(y), (mv < VV) ? 32'(mv) : 32'd0);
            if (sb.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e   = sb.pop_front();
                got = '{hs: hs, vs: vs, blank: blank_n, r: r, g: g, b: b};
                check_eq("hs", 32'(got.hs), 32'(e.hs));
                check_eq("vs", 32'(got.vs), 32'(e.vs));
                check_eq("blank_n", 32'(got.blank), 32'(e.blank));
                check_eq("rgb", 32'({got.r, got.g, got.b}), 32'({e.r, e.g, e.b}));
            end
            check_eq("frame_start", 32'(fs), 32'(prev_origin));

            if (blank_n) blank_cnt++;
            if (!hs) hs_low_cnt++;
            if (!vs) vs_low_cnt++;
            if (fs) fs_cnt++;
            if (last_hs && !hs && first_hs_fall < 0) first_hs_fall = i;
            last_hs = hs;

            col = 3'($urandom);
            {i_red, i_green, i_blue} = col;
`ifdef VGA_BORDER_EN
            bd = prev.border;
`else
            bd = 1'b0;
`endif
            e.hs = prev.hs;
            e.vs = prev.vs;
            e.blank = prev.blank;
            e.r = prev.blank & (col[2] | bd);
            e.g = prev.blank & (col[1] | bd);
            e.b = prev.blank & (col[0] | bd);
            sb.push_back(e);

            cur = stage0(mh, mv);
            prev = cur;
            prev_origin = (mh == 0 && mv == 0) ? 1'b1 : 1'b0;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("por");

        // First run: stop mid-frame at h=10, v=5 of the second frame.
        run_cycles(FRAME + 5 * HT + 10);
        check_eq("x_pre_rst", 32'(x), 32'(mh));
        check_eq("y_pre_rst", 32'(y), 32'(mv));

        // Asynchronous reset away from any clock edge.
        #2 reset = 1'b1;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        check_reset_state("rst_hold");

        // Second run: two full frames from a clean restart.
        run_cycles(2 * FRAME);
        check_eq("first_hs_fall", 32'(first_hs_fall), 32'(HV + HF + 2));
        check_eq("hs_low_cycles", 32'(hs_low_cnt), 32'(2 * VT * HSY));
        check_eq("vs_low_cycles", 32'(vs_low_cnt), 32'(2 * VSY * HT));
        check_eq("blank_cycles", 32'(blank_cnt), 32'(2 * HV * VV));
        check_eq("fs_pulses", 32'(fs_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
